// File: rtl/cv32e40p_instr_aligner.sv
// cv32e40p_instr_aligner: splits word-aligned fetch words into 16/32-bit instructions at halfword granularity
// Ports: clk/rst_n (sync active-low); fetch_* word in with fetch_ready_o consume strobe;
// instr_* aligned instruction out with PC and compressed flag; flush_i/flush_addr_i redirect.
module cv32e40p_instr_aligner #(
    parameter bit COMPRESSED = 1'b1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid_i,
    input  logic [31:0]           fetch_rdata_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_ready_o,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_is_compressed_o,
    input  logic                  instr_ready_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_addr_i
);
    typedef enum logic [1:0] {ALIGNED, HALF, BRANCH_HALF} state_t;
    state_t                state_q;
    logic [15:0]           half_q;
    logic [ADDR_WIDTH-1:0] pc_q, addr_p2, addr;
    logic [31:0]           rdata;
    logic                  full_lo, full_hi, half_full, valid, ready, acc, load;
    logic                  unused_flush_addr;
    assign unused_flush_addr = ^flush_addr_i;
    assign addr_p2   = fetch_addr_i + ADDR_WIDTH'(2);
    assign full_lo   = fetch_rdata_i[1:0] == 2'b11 || !COMPRESSED;
    assign full_hi   = fetch_rdata_i[17:16] == 2'b11;
    assign half_full = half_q[1:0] == 2'b11;
    always_comb begin
        valid = 1'b0;
        ready = 1'b0;
        rdata = fetch_rdata_i;
        addr  = fetch_addr_i;
        if (!rst_n) begin
            valid = 1'b0;
        end else if (flush_i) begin
            ready = fetch_valid_i;
        end else begin
            case (state_q)
                ALIGNED: begin
                    valid = fetch_valid_i;
                    rdata = full_lo ? fetch_rdata_i : {16'h0, fetch_rdata_i[15:0]};
                    ready = fetch_valid_i & instr_ready_i;
                end
                HALF: begin
                    valid = half_full ? fetch_valid_i : 1'b1;
                    rdata = half_full ? {fetch_rdata_i[15:0], half_q} : {16'h0, half_q};
                    addr  = pc_q;
                    ready = half_full & fetch_valid_i & instr_ready_i;
                end
                BRANCH_HALF: begin
                    valid = fetch_valid_i & !full_hi;
                    rdata = {16'h0, fetch_rdata_i[31:16]};
                    addr  = addr_p2;
                    // a 32-bit instr at the target needs the next word, so buffer the upper half unconditionally
                    ready = fetch_valid_i & (full_hi | instr_ready_i);
                end
                default: valid = 1'b0;
            endcase
        end
    end
    assign acc = valid & instr_ready_i;
    // the consumed word leaves its upper half behind as the start of the next instruction
    assign load = ready & (state_q == ALIGNED ? !full_lo : state_q == HALF ? 1'b1 : full_hi);
    assign fetch_ready_o         = ready;
    assign instr_valid_o         = valid;
    assign instr_rdata_o         = valid ? rdata : 32'h0;
    assign instr_addr_o          = valid ? addr : '0;
    assign instr_is_compressed_o = valid & (rdata[1:0] != 2'b11);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            half_q  <= 16'h0;
            pc_q    <= '0;
        end else if (flush_i) begin
            state_q <= (flush_addr_i[1] && COMPRESSED) ? BRANCH_HALF : ALIGNED;
        end else if (load) begin
            state_q <= HALF;
            half_q  <= fetch_rdata_i[31:16];
            pc_q    <= addr_p2;
        end else if (acc) begin
            state_q <= ALIGNED;
        end
    end
endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// tb_cv32e40p_instr_aligner: random and directed check of the aligner against a halfword-queue model
module tb_cv32e40p_instr_aligner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_is_compressed_o;
    logic        instr_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = 32'h0;
    cv32e40p_instr_aligner dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_valid_i(fetch_valid_i),
        .fetch_rdata_i(fetch_rdata_i),
        .fetch_addr_i(fetch_addr_i),
        .fetch_ready_o(fetch_ready_o),
        .instr_valid_o(instr_valid_o),
        .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o),
        .instr_is_compressed_o(instr_is_compressed_o),
        .instr_ready_i(instr_ready_i),
        .flush_i(flush_i),
        .flush_addr_i(flush_addr_i)
    );
    always #5 clk = ~clk;
    int          n_tests = 0;
    int          n_fail = 0;
    int          nb = 0;
    logic [15:0] bh = 16'h0;
    logic [31:0] ba = 32'h0;
    logic        skip = 1'b0;
    logic        last_fr = 1'b0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask
    task automatic step(input logic fv, input logic [31:0] w, input logic [31:0] a, input logic rdy,
                        input logic fl, input logic [31:0] tgt, input logic rn);
        logic [15:0] vh[3];
        logic [31:0] va[3];
        int          n, len, used, lim;
        logic        ev, ec, efr, acc;
        logic [31:0] ed, ea;
        @(negedge clk);
        rst_n = rn; fetch_valid_i = fv; fetch_rdata_i = w; fetch_addr_i = a;
        instr_ready_i = rdy; flush_i = fl; flush_addr_i = tgt;
        #2;
        n = 0;
        if (nb != 0) begin vh[0] = bh; va[0] = ba; n = 1; end
        if (fv) begin
            if (!skip) begin vh[n] = w[15:0]; va[n] = a; n++; end
            vh[n] = w[31:16]; va[n] = a + 32'd2; n++;
        end
        ev = 1'b0; ec = 1'b0; efr = 1'b0; ed = 32'h0; ea = 32'h0; used = 0; len = 1;
        if (!rn) begin
            nb = 0; skip = 1'b0;
        end else if (fl) begin
            efr = fv; nb = 0; skip = tgt[1];
        end else begin
            len = (n > 0 && vh[0][1:0] == 2'b11) ? 2 : 1;
            ev = n >= len;
            if (ev) begin
                ed = len == 2 ? {vh[1], vh[0]} : {16'h0, vh[0]};
                ea = va[0];
                ec = len == 1;
            end
            acc = ev && rdy;
            used = acc ? len : 0;
            efr = fv && (n - used) <= 1 && (acc || !ev);
            lim = efr ? n : nb;
            if (used < lim) begin nb = 1; bh = vh[used]; ba = va[used]; end else nb = 0;
            if (efr) skip = 1'b0;
        end
        chk("valid", 32'(instr_valid_o), 32'(ev));
        chk("rdata", instr_rdata_o, ed);
        chk("addr", instr_addr_o, ea);
        chk("is_compressed", 32'(instr_is_compressed_o), 32'(ec));
        chk("fetch_ready", 32'(fetch_ready_o), 32'(efr));
        last_fr = efr;
    endtask
    function automatic logic [15:0] rh();
        logic [15:0] h = 16'($urandom);
        if ($urandom_range(1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction
    logic [31:0] fa, w, tgt;
    logic        rn, fl, fv, rdy;
    initial begin
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00000013, 32'h0, 1, 0, 32'h0, 1);
        step(1, 32'h00100093, 32'h4, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00010001, 32'h0, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h4, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h4, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00130001, 32'h0, 1, 0, 32'h0, 1);
        step(1, 32'h12340000, 32'h4, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h8, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00010001, 32'h0, 1, 0, 32'h0, 1);
        step(1, 32'h55555555, 32'h4, 0, 1, 32'h102, 1);
        step(1, 32'h0001ABCD, 32'h100, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h104, 1, 0, 32'h0, 1);
        step(1, 32'h77777777, 32'h104, 1, 1, 32'h202, 1);
        step(1, 32'h0013ABCD, 32'h200, 1, 0, 32'h0, 1);
        step(1, 32'h0000FFFF, 32'h204, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h208, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00010001, 32'h0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h00000013, 32'h4, 0, 0, 32'h0, 1);
        step(1, 32'h00000013, 32'h4, 0, 0, 32'h0, 0);
        step(1, 32'h00000013, 32'h4, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
        step(1, 32'h00050001, 32'hFFFFFFFC, 1, 0, 32'h0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 32'h0, 1);
        step(1, 32'hC0DE0003, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFFE, 1);
        step(1, 32'h12345678, 32'hFFFFFFFC, 1, 0, 32'h0, 1);
        fa = 32'h1000;
        w = {rh(), rh()};
        for (int c = 0; c < 4000; c++) begin
            rn  = $urandom_range(99) != 0;
            fl  = $urandom_range(19) == 0;
            tgt = $urandom & 32'hFFFF_FFFE;
            fv  = $urandom_range(3) != 0;
            rdy = $urandom_range(9) < 7;
            step(fv, w, fa, rdy, fl, tgt, rn);
            if (rn && fl) begin
                fa = tgt & ~32'h3;
                w = {rh(), rh()};
            end else if (rn && last_fr) begin
                fa = fa + 32'd4;
                w = {rh(), rh()};
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
